// File: rtl/vga_sprite_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_sprite_renderer_pkg
// Description : Shared constants, mode encodings and band colour table for the
//               VGA sprite renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_sprite_renderer_pkg;

    localparam int ENT_NOTHING = 0;

    typedef enum logic [1:0] {
        MODE_GAME  = 2'd0,
        MODE_HBARS = 2'd1,
        MODE_VBARS = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    // {R,G,B} on/off masks; index 7 is the leftmost entry.
    localparam logic [7:0][2:0] BAND_MASK = {
        3'b000,  // 7 black
        3'b010,  // 6 green
        3'b001,  // 5 blue
        3'b011,  // 4 cyan
        3'b100,  // 3 red
        3'b110,  // 2 yellow
        3'b101,  // 1 magenta
        3'b111   // 0 white
    };

    // Comparator chain giving min(7, v / len) without a divider.
    function automatic logic [2:0] band_of(input int v, input int len);
        logic [2:0] b;
        b = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (v >= k * len) begin
                b = 3'(k);
            end
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sprite_ram.sv
`default_nettype none
// ============================================================================
// Module      : vga_sprite_ram
// Description : Single-clock sprite RAM, one write port and one registered
//               read port; read-first on address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sprite_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module      : vga_sprite_renderer
// Description : Two-stage pixel pipeline turning pixel coordinates and tile
//               entity codes into RGB, with test patterns and a blinking entity.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sprite_renderer #(
    parameter int COLOR_W      = 1,
    parameter int ENT_W        = 2,
    parameter int SQ_LOG2_H    = 4,
    parameter int SQ_LOG2_V    = 4,
    parameter int BAND_H       = 60,
    parameter int BLINK_ENT    = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                 iVGA_CLK,
    input  logic                                 reset_n,
    input  logic [9:0]                           iVGA_X,
    input  logic [9:0]                           iVGA_Y,
    input  logic                                 iBlank_n,
    input  logic                                 iFrame_Start,
    input  logic [ENT_W-1:0]                     iEnt,
    input  logic [1:0]                           iMode,
    input  logic                                 iBlink_En,
    input  logic                                 iSpr_We,
    input  logic [ENT_W+SQ_LOG2_V+SQ_LOG2_H-1:0] iSpr_Addr,
    input  logic [3*COLOR_W-1:0]                 iSpr_Data,
    output logic [COLOR_W-1:0]                   oRed,
    output logic [COLOR_W-1:0]                   oGreen,
    output logic [COLOR_W-1:0]                   oBlue,
    output logic                                 oBlank_n
);

    import vga_sprite_renderer_pkg::*;

    localparam int ADDR_W = ENT_W + SQ_LOG2_V + SQ_LOG2_H;
    localparam int DATA_W = 3 * COLOR_W;
    localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    mode_e              active_mode_q, mode_now;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;

    mode_e              mode_q;
    logic [ENT_W-1:0]   ent_q;
    logic               blank_q, chk_q, hide_q;
    logic [2:0]         band_q, band_d;

    logic [DATA_W-1:0]  spr_rd;
    logic [DATA_W-1:0]  color_d, rgb_q;
    logic [2:0]         mask_w;
    logic               blank2_q;

    // A frame-start pixel already uses the newly requested mode.
    always_comb begin
        mode_now = iFrame_Start ? mode_e'(iMode) : active_mode_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (iFrame_Start) begin
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        band_d = (mode_now == MODE_HBARS) ? band_of(int'(iVGA_Y), BAND_H)
                                          : band_of(int'(iVGA_X), 80);
    end

    vga_sprite_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (iVGA_CLK),
        .we_i    (iSpr_We),
        .waddr_i (iSpr_Addr),
        .wdata_i (iSpr_Data),
        .raddr_i ({iEnt, iVGA_Y[SQ_LOG2_V-1:0], iVGA_X[SQ_LOG2_H-1:0]}),
        .rdata_o (spr_rd)
    );

    always_ff @(posedge iVGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            active_mode_q <= MODE_GAME;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
            mode_q        <= MODE_GAME;
            ent_q         <= '0;
            blank_q       <= 1'b0;
            chk_q         <= 1'b0;
            hide_q        <= 1'b0;
            band_q        <= 3'd0;
        end else begin
            active_mode_q <= mode_now;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            mode_q        <= mode_now;
            ent_q         <= iEnt;
            blank_q       <= iBlank_n;
            chk_q         <= iVGA_X[SQ_LOG2_H] ^ iVGA_Y[SQ_LOG2_V];
            hide_q        <= (iEnt == ENT_W'(BLINK_ENT)) && iBlink_En && phase_q;
            band_q        <= band_d;
        end
    end

    always_comb begin
        mask_w  = BAND_MASK[band_q];
        color_d = '0;
        case (mode_q)
            MODE_GAME: begin
                if ((ent_q != ENT_W'(ENT_NOTHING)) && !hide_q) begin
                    color_d = spr_rd;
                end
            end
            MODE_HBARS, MODE_VBARS: begin
                color_d = {{COLOR_W{mask_w[2]}}, {COLOR_W{mask_w[1]}}, {COLOR_W{mask_w[0]}}};
            end
            MODE_CHECK: begin
                color_d = chk_q ? '1 : '0;
            end
            default: color_d = '0;
        endcase
        if (!blank_q) begin
            color_d = '0;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q    <= '0;
            blank2_q <= 1'b0;
        end else begin
            rgb_q    <= color_d;
            blank2_q <= blank_q;
        end
    end

    assign oRed     = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign oGreen   = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign oBlue    = rgb_q[COLOR_W-1:0];
    assign oBlank_n = blank2_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sprite_renderer
// Description : Directed and randomised bench for vga_sprite_renderer against
//               a behavioural pixel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sprite_renderer;

    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] vx, vy;
    logic       blank_n, frame_start;
    logic [1:0] ent, mode;
    logic       blink_en, spr_we;
    logic [9:0] spr_addr;
    logic [2:0] spr_data;
    logic       o_r, o_g, o_b, o_blank;

    always #5 clk = ~clk;

    vga_sprite_renderer #(
        .BLINK_FRAMES (BF)
    ) dut (
        .iVGA_CLK     (clk),
        .reset_n      (reset_n),
        .iVGA_X       (vx),
        .iVGA_Y       (vy),
        .iBlank_n     (blank_n),
        .iFrame_Start (frame_start),
        .iEnt         (ent),
        .iMode        (mode),
        .iBlink_En    (blink_en),
        .iSpr_We      (spr_we),
        .iSpr_Addr    (spr_addr),
        .iSpr_Data    (spr_data),
        .oRed         (o_r),
        .oGreen       (o_g),
        .oBlue        (o_b),
        .oBlank_n     (o_blank)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0] m_mem [1024];
    int         m_mode;
    int         m_frames;
    logic [1:0] g_md;
    logic       g_ben;

    logic [3:0] q_exp  [$];
    bit         q_chk  [$];
    bit         q_hw   [$];
    logic [3:0] q_want [$];
    string      q_tag  [$];

    function automatic logic [2:0] band_rgb(input int b);
        case (b)
            0: return 3'b111;
            1: return 3'b101;
            2: return 3'b110;
            3: return 3'b100;
            4: return 3'b011;
            5: return 3'b001;
            6: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected {blank_n, R, G, B} for one pixel.
    function automatic logic [3:0] ref_pix(input logic [9:0] x, input logic [9:0] y,
                                           input logic [1:0] e, input logic bl,
                                           input int md, input int phase, input logic ben);
        int b;
        if (!bl) return 4'b0000;
        case (md)
            0: begin
                if (e == 2'd0) return 4'b1000;
                if (e == 2'd2 && ben && phase == 1) return 4'b1000;
                return {1'b1, m_mem[{e, y[3:0], x[3:0]}]};
            end
            1: begin
                b = int'(y) / 60;
                if (b > 7) b = 7;
                return {1'b1, band_rgb(b)};
            end
            2: begin
                b = int'(x) / 80;
                if (b > 7) b = 7;
                return {1'b1, band_rgb(b)};
            end
            default: return (x[4] ^ y[4]) ? 4'b1111 : 4'b1000;
        endcase
    endfunction

    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic [1:0] e,
                        input logic bl, input logic fs, input logic [1:0] md, input logic ben,
                        input logic we, input logic [9:0] wa, input logic [2:0] wd,
                        input bit chk, input bit hw, input logic [3:0] want, input string tag);
        logic [3:0] pe, pw, obs;
        bit         pc, ph;
        string      pt;
        @(negedge clk);
        vx = x; vy = y; ent = e; blank_n = bl; frame_start = fs; mode = md;
        blink_en = ben; spr_we = we; spr_addr = wa; spr_data = wd;
        q_exp.push_back(ref_pix(x, y, e, bl, fs ? int'(md) : m_mode, (m_frames / BF) % 2, ben));
        q_chk.push_back(chk); q_hw.push_back(hw); q_want.push_back(want); q_tag.push_back(tag);
        if (fs) begin
            m_mode = int'(md);
            m_frames++;
        end
        if (we) m_mem[wa] = wd;
        @(posedge clk);
        #1;
        if (q_exp.size() >= 2) begin
            pe = q_exp.pop_front(); pc = q_chk.pop_front(); ph = q_hw.pop_front();
            pw = q_want.pop_front(); pt = q_tag.pop_front();
            obs = {o_blank, o_r, o_g, o_b};
            if (pc) begin
                n_assert++;
                assert (obs === pe) else begin
                    n_fail++;
                    $error("FAIL %s model: observed %b expected %b", pt, obs, pe);
                end
            end
            if (ph) begin
                n_assert++;
                assert (obs === pw) else begin
                    n_fail++;
                    $error("FAIL %s: observed %b expected %b", pt, obs, pw);
                end
            end
        end
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [1:0] e,
                       input logic bl, input logic [3:0] want, input string tag);
        step(x, y, e, bl, 1'b0, g_md, g_ben, 1'b0, 10'd0, 3'd0, 1'b1, 1'b1, want, tag);
    endtask

    task automatic wr(input logic [9:0] wa, input logic [2:0] wd);
        step(10'd0, 10'd0, 2'd0, 1'b0, 1'b0, g_md, g_ben, 1'b1, wa, wd, 1'b1, 1'b0, 4'd0, "wr");
    endtask

    task automatic fstart(input logic [1:0] md);
        g_md = md;
        step(10'd0, 10'd0, 2'd0, 1'b0, 1'b1, md, g_ben, 1'b0, 10'd0, 3'd0, 1'b1, 1'b0, 4'd0, "fs");
    endtask

    task automatic chk_now(input string tag);
        logic [3:0] obs;
        obs = {o_blank, o_r, o_g, o_b};
        n_assert++;
        assert (obs === 4'b0000) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected 0000", tag, obs);
        end
    endtask

    // Asserts reset mid-cycle with active pixels on the inputs, then releases.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_now("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vx = 10'd21; vy = 10'd35; ent = 2'd1; blank_n = 1'b1; spr_we = 1'b0;
            @(posedge clk);
            #1;
            chk_now("rst_hold");
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        q_exp.delete(); q_chk.delete(); q_hw.delete(); q_want.delete(); q_tag.delete();
        q_exp.push_back(4'b0000); q_chk.push_back(1'b1); q_hw.push_back(1'b1);
        q_want.push_back(4'b0000); q_tag.push_back("rst_first_edge");
        m_mode   = 0;
        m_frames = 0;
        g_md     = 2'd0;
    endtask

    initial begin
        logic [9:0] rx, ry, ra;
        logic [1:0] re, rm;
        logic       rfs;

        reset_n = 1'b0;
        vx = '0; vy = '0; ent = '0; blank_n = 1'b0; frame_start = 1'b0; mode = '0;
        blink_en = 1'b0; spr_we = 1'b0; spr_addr = '0; spr_data = '0;
        g_md = 2'd0; g_ben = 1'b0; m_mode = 0; m_frames = 0;

        for (int a = 0; a < 1024; a++) wr(10'(a), 3'($urandom));

        do_reset();
        pix(10'd0, 10'd0, 2'd0, 1'b1, 4'b1000, "first_px");

        wr(10'h135, 3'b101);
        pix(10'd21, 10'd35, 2'd1, 1'b1, 4'b1101, "spr_rd");
        pix(10'd21, 10'd35, 2'd0, 1'b1, 4'b1000, "ent0");

        g_md = 2'd1;
        pix(10'd21, 10'd35, 2'd1, 1'b1, 4'b1101, "mode_hold");
        fstart(2'd1);
        pix(10'd5, 10'd130, 2'd1, 1'b1, 4'b1110, "hbar_y130");
        pix(10'd5, 10'd479, 2'd1, 1'b1, 4'b1000, "hbar_y479");
        fstart(2'd2);
        pix(10'd400, 10'd0, 2'd1, 1'b1, 4'b1001, "vbar_x400");
        pix(10'd639, 10'd0, 2'd1, 1'b1, 4'b1000, "vbar_x639");

        g_md = 2'd3;
        step(10'd16, 10'd0, 2'd0, 1'b1, 1'b1, 2'd3, g_ben, 1'b0, 10'd0, 3'd0,
             1'b1, 1'b1, 4'b1111, "fs_same_cycle");
        pix(10'd0, 10'd0, 2'd0, 1'b1, 4'b1000, "chk_00");
        pix(10'd16, 10'd0, 2'd0, 1'b1, 4'b1111, "chk_16_0");
        pix(10'd16, 10'd16, 2'd0, 1'b1, 4'b1000, "chk_16_16");

        do_reset();
        wr(10'h200, 3'b111);
        g_ben = 1'b1;
        for (int f = 0; f < 5; f++) begin
            if (f > 0) fstart(2'd0);
            pix(10'd0, 10'd0, 2'd2, 1'b1, (f == 2 || f == 3) ? 4'b1000 : 4'b1111, "blink");
        end
        fstart(2'd0);
        fstart(2'd0);
        pix(10'd0, 10'd0, 2'd2, 1'b1, 4'b1000, "blink_on_phase1");
        g_ben = 1'b0;
        pix(10'd0, 10'd0, 2'd2, 1'b1, 4'b1111, "blink_off");
        pix(10'd0, 10'd0, 2'd2, 1'b0, 4'b0000, "blank_white");

        step(10'd21, 10'd35, 2'd1, 1'b1, 1'b0, g_md, g_ben, 1'b1, 10'h135, 3'b010,
             1'b1, 1'b1, 4'b1101, "coll_old");
        pix(10'd21, 10'd35, 2'd1, 1'b1, 4'b1010, "coll_new");

        for (int i = 0; i < 3000; i++) begin
            rx  = 10'($urandom_range(0, 799));
            ry  = 10'($urandom_range(0, 524));
            re  = 2'($urandom);
            rfs = ($urandom_range(0, 23) == 0);
            rm  = rfs ? 2'($urandom) : g_md;
            if (rfs) g_md = rm;
            ra  = $urandom_range(0, 1) ? {re, ry[3:0], rx[3:0]} : 10'($urandom);
            step(rx, ry, re, ($urandom_range(0, 4) != 0), rfs, rm, 1'($urandom),
                 ($urandom_range(0, 3) == 0), ra, 3'($urandom), 1'b1, 1'b0, 4'd0, "random");
        end
        step(10'd0, 10'd0, 2'd0, 1'b0, 1'b0, g_md, 1'b0, 1'b0, 10'd0, 3'd0,
             1'b1, 1'b0, 4'd0, "flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sprite_renderer.md
Name: vga_sprite_renderer

Overview:
- Parametrised successor to the single-bit VGA pattern stage. Converts the current pixel coordinate and its grid entity code into RGB output.
- Uses a run-time-writable sprite RAM, multi-bit colour channels, frame-synchronised mode switching, a blinking entity and several test patterns.
- Sits between the VGA timing controller (pixel X/Y, blank, frame start) and the DAC output.
- Fixed 2-cycle pipeline; the blank signal is delayed alongside the pixel data.

Parameters:
- COLOR_W, 1: bits per colour channel.
- ENT_W, 2: entity code width. Code 0 means "nothing" and renders black.
- SQ_LOG2_H, 4: log2 of tile width in pixels (16).
- SQ_LOG2_V, 4: log2 of tile height in pixels (16).
- BAND_H, 60: test-bar band height in lines.
- BLINK_ENT, 2: entity code that blinks.
- BLINK_FRAMES, 30: frames per blink half-period. Must be at least 1.

Ports:
- iVGA_CLK  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- iVGA_X  in  10  pixel column.
- iVGA_Y  in  10  pixel line.
- iBlank_n  in  1  1 = active video.
- iFrame_Start  in  1  one-cycle pulse at the first pixel of each frame.
- iEnt  in  ENT_W  entity at the current tile.
- iMode  in  2  0 = game, 1 = horizontal colour bars, 2 = vertical colour bars, 3 = checkerboard.
- iBlink_En  in  1  enables blinking of BLINK_ENT.
- iSpr_We  in  1  sprite RAM write strobe.
- iSpr_Addr  in  ENT_W+SQ_LOG2_V+SQ_LOG2_H  write address, laid out as {ent, ly, lx}.
- iSpr_Data  in  3*COLOR_W  write data, laid out as {R, G, B}.
- oRed, oGreen, oBlue  out  COLOR_W each.
- oBlank_n  out  1  iBlank_n delayed by 2 cycles.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - oRed, oGreen, oBlue = 0; oBlank_n = 0.
  - Pipeline registers = 0; frame counter = 0; blink phase = 0; active mode = 0.
  - Sprite RAM contents are not cleared.
- Reset asserted mid-line: outputs go to 0 immediately. The first valid pixel appears 2 cycles after the first clock edge following release.
- Local tile coordinates: lx = iVGA_X[SQ_LOG2_H-1:0], ly = iVGA_Y[SQ_LOG2_V-1:0]. No division is used.
- Stage 1 (cycle t+1):
  - Register mode, entity, blank, band index and checker bit.
  - Issue a synchronous sprite RAM read at {iEnt, ly, lx}.
- Stage 2 (cycle t+2):
  - Select the colour and register it onto the outputs.
  - If the delayed blank_n = 0, the outputs are forced to 0.
- Total latency is 2 cycles for every mode.
- Mode latch:
  - iMode is sampled into active_mode only on the cycle iFrame_Start = 1.
  - A mode change mid-frame therefore has no effect until the next frame (no tearing).
- Game mode:
  - ent = 0 → black.
  - ent = BLINK_ENT, iBlink_En = 1 and blink phase = 1 → black.
  - Otherwise → sprite RAM data.
- Horizontal bars: band = min(7, iVGA_Y / BAND_H), implemented as a comparator chain against k*BAND_H.
- Vertical bars: band = min(7, iVGA_X / 80).
- Band colours, bands 0 to 7: white, magenta, yellow, red, cyan, blue, green, black.
  - A channel is "on" when it is all ones ({COLOR_W{1'b1}}) and "off" when 0.
- Checkerboard: white when (iVGA_X[SQ_LOG2_H] XOR iVGA_Y[SQ_LOG2_V]) = 1, black otherwise.
- Blink counter:
  - Increments on each iFrame_Start.
  - On reaching BLINK_FRAMES-1 with iFrame_Start = 1, it wraps to 0 and the blink phase toggles.
  - The counter runs regardless of iBlink_En.
- Sprite RAM:
  - Size: 2^(ENT_W+SQ_LOG2_V+SQ_LOG2_H) words of 3*COLOR_W bits, single clock.
  - Write occurs on the iVGA_CLK edge when iSpr_We = 1.
  - A simultaneous read and write to the same address returns the old data (read-first).
  - The ent = 0 region is writable but never displayed.
- iFrame_Start together with iBlank_n = 1 on the same cycle is legal. The pixel on that cycle already uses the new mode, because the mode latch feeds stage 1 combinationally on that cycle.

Decomposition:
- Shared package/header holds:
  - ENT_NOTHING = 0.
  - Mode encodings MODE_GAME, MODE_HBARS, MODE_VBARS, MODE_CHECK.
  - The 8-entry band colour table, stored as 3-bit on/off masks.
- One natural sub-module: vga_sprite_ram, a parametrised synchronous single-port-write / single-port-read RAM with read-first behaviour.

Test Plan:
- Reset: hold reset_n = 0 while driving active pixels → outputs = 0 and oBlank_n = 0. Release, then drive X = 0, Y = 0, iBlank_n = 1 → oBlank_n = 1 exactly 2 cycles later.
- Sprite write then read:
  - Write {ent=1, ly=3, lx=5} with data R=1, G=0, B=1.
  - Scan X = 21, Y = 35, iEnt = 1, mode 0 → output (1, 0, 1) at t+2.
  - Same pixel with iEnt = 0 → output (0, 0, 0).
- Frame-latched mode:
  - Set iMode = 1 mid-frame → output keeps game data.
  - After the iFrame_Start pulse, line Y = 130 → yellow (1, 1, 0); line Y = 479 → black.
- Blink (BLINK_FRAMES = 2, iBlink_En = 1, ent = 2 sprite white):
  - Frames 0–1 show white.
  - Frames 2–3 show black.
  - Frame 4 shows white again.
  - With iBlink_En = 0 the pixel is always white.
- Blank and collision:
  - iBlank_n = 0 with a white sprite → output 0.
  - A write to the same address in the same cycle as the read returns the old value, then the new value on the next scan.
- Checkerboard, mode 3: (X=0, Y=0) → black; (X=16, Y=0) → white; (X=16, Y=16) → black.
